mania_lane_renderer: RTL and testbench
======================================

MANIA_LANE_RENDERER -- requirements
Module: mania_lane_renderer

Interface
REQ-001 The module SHALL have parameters: LANE_X0, default 192, left column of lane 0; LANE_W, default 64, lane width in pixels; HIT_ROW, default 400, hit-line row; NOTE_H, default 16, note height in rows; SCROLL, default 2, rows advanced per frame; WINDOW, default 24, hit tolerance in rows.
REQ-002 clk  input  1  pixel clock, the same clock that drives the VGA controller.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 row_addr  input  9  requested pixel row, 0..479, from the VGA controller.
REQ-005 col_addr  input  10  requested pixel column, 0..639, from the VGA controller.
REQ-006 rdn  input  1  active-low pixel request; low means the display area is active.
REQ-007 spawn_valid  input  1  new-note request.
REQ-008 spawn_lane  input  2  lane of the new note.
REQ-009 spawn_ready  output  1  a free slot exists in spawn_lane (combinational from slot state and spawn_lane).
REQ-010 key  input  4  lane keys, active-high, already synchronised to clk.
REQ-011 d_out  output  12  pixel colour {r,g,b}, 4 bits each, returned to the VGA controller's d_in.
REQ-012 hit_pulse  output  4  one-cycle pulse per lane on a successful hit.
REQ-013 miss_pulse  output  4  one-cycle pulse per lane when a note leaves the screen.

Function
REQ-014 Each lane SHALL hold 4 note slots, each a valid bit plus a 10-bit top row y.
REQ-015 A spawn SHALL be accepted when spawn_valid and spawn_ready are both high; the lowest-index free slot in spawn_lane becomes valid with y=0.
REQ-016 frame_tick SHALL pulse for one cycle when rdn is low, row_addr==0 and the registered previous row_addr was nonzero.
REQ-017 On frame_tick, every valid slot SHALL update y<=y+SCROLL; a slot whose result is >=480 is cleared and raises its lane's miss_pulse for one cycle, with multiple misses in one lane ORed.
REQ-018 A key rising edge SHALL be detected against a registered copy of key.
REQ-019 On a rising edge in lane L, the valid slot with the largest y satisfying |y+NOTE_H/2-HIT_ROW|<=WINDOW SHALL be cleared and hit_pulse[L] asserted; with no such slot, nothing happens.
REQ-020 Spawn and frame_tick in the same cycle: the spawned slot SHALL hold y=0 and is not advanced that cycle.
REQ-021 Key edge and frame_tick in the same cycle: the hit test SHALL use pre-advance y; the hit slot is cleared, not advanced, and raises no miss.
REQ-022 Spawn into a full lane SHALL be ignored, with no slot change.
REQ-023 Pixel output SHALL be registered with a latency of 1 cycle from row_addr/col_addr/rdn to d_out.
REQ-024 Colour priority: rdn high -> 12'h000; inside a valid note (column in lane, y<=row<y+NOTE_H) -> lane colour (12'hf00, 12'h0f0, 12'h00f, 12'hff0); row==HIT_ROW within lanes -> 12'hfff; column == lane left edge -> 12'h888; key[L] held inside lane L -> 12'h222; otherwise 12'h000.
REQ-025 Columns outside LANE_X0..LANE_X0+4*LANE_W-1 SHALL output 12'h000 when not blanked.

Reset
REQ-026 While rst is high at a clock edge: all slots invalid, d_out=12'h000, hit_pulse=0, miss_pulse=0, key and row history registers=0.
REQ-027 Reset mid-frame SHALL discard all notes; frame_tick detection resumes at the next row wrap.

Configuration
REQ-028 With MANIA_HIT_FLASH_EN defined, each lane SHALL have a 3-bit flash counter loaded with 7 on hit and decremented on each frame_tick; while it is nonzero, that lane's hit-line pixels are 12'h0f0 instead of 12'hfff; counters reset to 0.
REQ-029 Without MANIA_HIT_FLASH_EN, no flash counters SHALL exist and the hit line is always 12'hfff.

Verification
REQ-030 Spawn lane 1, then 200 frame ticks -> y=400, d_out at (row 400, col 256+1) = 12'h0f0 one cycle after the request.
REQ-031 Spawn 5 notes into lane 0 back-to-back -> spawn_ready low after the 4th, 5th ignored, 4 slots valid.
REQ-032 Note at y=388, key[2] rising -> hit_pulse=4'b0100 for exactly one cycle, slot cleared; key rising with y=300 -> no pulse.
REQ-033 Note at y=478, frame_tick -> slot cleared, miss_pulse one cycle.
REQ-034 Spawn and frame_tick in the same cycle -> new note y=0; existing notes advanced by SCROLL.
REQ-035 rdn high with any address -> d_out=12'h000 next cycle; rst asserted mid-frame -> all outputs 0 and no notes drawn.

Source files
------------

// File: rtl/mania_lane_renderer.sv
// Four-lane falling-note renderer for a VGA pixel pipeline: note slots, scroll, hit/miss detection, pixel colour.
// Optional per-lane hit flash on the hit line is enabled by defining MANIA_HIT_FLASH_EN.
module mania_lane_renderer #(
  parameter int LANE_X0 = 192,
  parameter int LANE_W  = 64,
  parameter int HIT_ROW = 400,
  parameter int NOTE_H  = 16,
  parameter int SCROLL  = 2,
  parameter int WINDOW  = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        rdn,
  input  logic        spawn_valid,
  input  logic [1:0]  spawn_lane,
  output logic        spawn_ready,
  input  logic [3:0]  key,
  output logic [11:0] d_out,
  output logic [3:0]  hit_pulse,
  output logic [3:0]  miss_pulse
);

  logic [3:0][3:0]       valid_q, valid_d;
  logic [3:0][3:0][9:0]  y_q, y_d;
  logic [8:0]            row_prev_q, row_prev_d;
  logic [3:0]            key_prev_q, key_prev_d;
  logic [11:0]           d_out_q, d_out_d;
  logic [3:0]            hit_pulse_q, hit_pulse_d;
  logic [3:0]            miss_pulse_q, miss_pulse_d;
  logic [3:0]            flash_on;

  logic                  frame_tick;
  logic [3:0]            key_edge;
  logic [3:0]            hit_found;
  logic [3:0][1:0]       hit_idx;

  assign spawn_ready = ~&valid_q[spawn_lane];
  assign frame_tick  = ~rdn && (row_addr == 9'd0) && (row_prev_q != 9'd0);
  assign key_edge    = key & ~key_prev_q;

  assign d_out      = d_out_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;

`ifdef MANIA_HIT_FLASH_EN
  logic [3:0][2:0] flash_q, flash_d;

  always_comb begin
    flash_d = flash_q;
    for (int l = 0; l < 4; l++) begin
      if (hit_pulse_d[l]) begin
        flash_d[l] = 3'd7;
      end else if (frame_tick && (flash_q[l] != 3'd0)) begin
        flash_d[l] = flash_q[l] - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) flash_q <= '0;
    else     flash_q <= flash_d;
  end

  always_comb begin
    for (int l = 0; l < 4; l++) flash_on[l] = (flash_q[l] != 3'd0);
  end
`else
  assign flash_on = 4'b0000;
`endif

  // Per lane, pick the valid slot lowest on screen whose centre lies within the hit window.
  always_comb begin : hit_search
    int centre;
    hit_found = '0;
    hit_idx   = '0;
    for (int l = 0; l < 4; l++) begin
      for (int s = 0; s < 4; s++) begin
        centre = int'(y_q[l][s]) + NOTE_H / 2;
        if (valid_q[l][s] && (centre >= HIT_ROW - WINDOW) && (centre <= HIT_ROW + WINDOW) &&
            (!hit_found[l] || (y_q[l][s] > y_q[l][hit_idx[l]]))) begin
          hit_found[l] = 1'b1;
          hit_idx[l]   = 2'(s);
        end
      end
    end
  end

  always_comb begin : slot_update
    logic [10:0] sum;
    logic        placed;
    valid_d      = valid_q;
    y_d          = y_q;
    hit_pulse_d  = '0;
    miss_pulse_d = '0;
    sum          = '0;
    placed       = 1'b0;
    for (int l = 0; l < 4; l++) begin
      if (key_edge[l] && hit_found[l]) begin
        valid_d[l][hit_idx[l]] = 1'b0;
        hit_pulse_d[l]         = 1'b1;
      end
    end
    // Slots just cleared by a hit are skipped here, so they never also miss.
    if (frame_tick) begin
      for (int l = 0; l < 4; l++) begin
        for (int s = 0; s < 4; s++) begin
          if (valid_d[l][s]) begin
            sum = {1'b0, y_q[l][s]} + 11'(SCROLL);
            if (sum >= 11'd480) begin
              valid_d[l][s]   = 1'b0;
              miss_pulse_d[l] = 1'b1;
            end else begin
              y_d[l][s] = sum[9:0];
            end
          end
        end
      end
    end
    if (spawn_valid && spawn_ready) begin
      for (int s = 0; s < 4; s++) begin
        if (!placed && !valid_q[spawn_lane][s]) begin
          valid_d[spawn_lane][s] = 1'b1;
          y_d[spawn_lane][s]     = 10'd0;
          placed                 = 1'b1;
        end
      end
    end
    row_prev_d = row_addr;
    key_prev_d = key;
  end

  // Lanes are disjoint column ranges, so at most one lane writes the pixel.
  always_comb begin : pixel
    int col;
    int row;
    logic in_note;
    col     = int'(col_addr);
    row     = int'(row_addr);
    d_out_d = 12'h000;
    in_note = 1'b0;
    if (!rdn) begin
      for (int l = 0; l < 4; l++) begin
        if ((col >= LANE_X0 + l * LANE_W) && (col < LANE_X0 + (l + 1) * LANE_W)) begin
          in_note = 1'b0;
          for (int s = 0; s < 4; s++) begin
            if (valid_q[l][s] && (row >= int'(y_q[l][s])) && (row < int'(y_q[l][s]) + NOTE_H))
              in_note = 1'b1;
          end
          if (in_note) begin
            case (l)
              0:       d_out_d = 12'hf00;
              1:       d_out_d = 12'h0f0;
              2:       d_out_d = 12'h00f;
              default: d_out_d = 12'hff0;
            endcase
          end else if (row == HIT_ROW) begin
            d_out_d = flash_on[l] ? 12'h0f0 : 12'hfff;
          end else if (col == LANE_X0 + l * LANE_W) begin
            d_out_d = 12'h888;
          end else if (key[l]) begin
            d_out_d = 12'h222;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      y_q          <= '0;
      row_prev_q   <= '0;
      key_prev_q   <= '0;
      d_out_q      <= '0;
      hit_pulse_q  <= '0;
      miss_pulse_q <= '0;
    end else begin
      valid_q      <= valid_d;
      y_q          <= y_d;
      row_prev_q   <= row_prev_d;
      key_prev_q   <= key_prev_d;
      d_out_q      <= d_out_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
    end
  end

endmodule

// File: tb/tb_mania_lane_renderer.sv
// Self-checking bench for mania_lane_renderer: directed scenarios plus randomized traffic against a note-list model.
module tb_mania_lane_renderer;

   localparam int LX0 = 192;
   localparam int LW = 64;
   localparam int HROW = 400;
   localparam int NH = 16;
   localparam int SCR = 2;
   localparam int WIN = 24;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [8:0] row_addr = '0;
   logic [9:0] col_addr = '0;
   logic rdn = 1'b1;
   logic spawn_valid = 1'b0;
   logic [1:0] spawn_lane = '0;
   logic spawn_ready;
   logic [3:0] key = '0;
   logic [11:0] d_out;
   logic [3:0] hit_pulse;
   logic [3:0] miss_pulse;

   int checkCount = 0;
   int passCount = 0;

   // Model: per lane an unordered list of note top rows (at most four).
   int noteY[4][4];
   int noteCnt[4];
   int prevRow;
   logic [3:0] prevKey;

   mania_lane_renderer dut (
      .clk(clk), .rst(rst), .row_addr(row_addr), .col_addr(col_addr), .rdn(rdn),
      .spawn_valid(spawn_valid), .spawn_lane(spawn_lane), .spawn_ready(spawn_ready),
      .key(key), .d_out(d_out), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
   endtask

   function automatic logic [11:0] expPixel(input logic r, input int row, input int col, input logic [3:0] k);
      int l;
      if (r) return 12'h000;
      if (col < LX0 || col >= LX0 + 4 * LW) return 12'h000;
      l = (col - LX0) / LW;
      for (int i = 0; i < noteCnt[l]; i++)
         if (row >= noteY[l][i] && row < noteY[l][i] + NH)
            return (l == 0) ? 12'hf00 : (l == 1) ? 12'h0f0 : (l == 2) ? 12'h00f : 12'hff0;
      if (row == HROW) return 12'hfff;
      if (col == LX0 + l * LW) return 12'h888;
      if (k[l]) return 12'h222;
      return 12'h000;
   endfunction

   task automatic removeNote(input int l, input int i);
      noteY[l][i] = noteY[l][noteCnt[l] - 1];
      noteCnt[l]--;
   endtask

   task automatic clearModel();
      for (int l = 0; l < 4; l++) noteCnt[l] = 0;
      prevRow = 0;
      prevKey = 4'b0000;
   endtask

   // One clock of stimulus; checks spawn_ready before the edge and registered outputs after it.
   task automatic applyStimulus(input logic r, input int row, input int col, input logic [3:0] k,
                                input logic sv, input logic [1:0] sl);
      logic [11:0] expPix;
      logic [3:0] expHit, expMiss, edges;
      logic tick, ready;
      int best;
      @(negedge clk);
      rst = 1'b0;
      rdn = r;
      row_addr = 9'(row);
      col_addr = 10'(col);
      key = k;
      spawn_valid = sv;
      spawn_lane = sl;
      #1;
      ready = (noteCnt[sl] < 4);
      checkOutput("spawn_ready", {31'd0, spawn_ready}, {31'd0, ready});
      expPix = expPixel(r, row, col, k);
      tick = !r && row == 0 && prevRow != 0;
      edges = k & ~prevKey;
      expHit = '0;
      expMiss = '0;
      for (int l = 0; l < 4; l++) begin
         if (edges[l]) begin
            best = -1;
            for (int i = 0; i < noteCnt[l]; i++) begin
               int d;
               d = noteY[l][i] + NH / 2 - HROW;
               if (d < 0) d = -d;
               if (d <= WIN && (best < 0 || noteY[l][i] > noteY[l][best])) best = i;
            end
            if (best >= 0) begin
               removeNote(l, best);
               expHit[l] = 1'b1;
            end
         end
      end
      if (tick) begin
         for (int l = 0; l < 4; l++) begin
            for (int i = noteCnt[l] - 1; i >= 0; i--) begin
               noteY[l][i] += SCR;
               if (noteY[l][i] >= 480) begin
                  removeNote(l, i);
                  expMiss[l] = 1'b1;
               end
            end
         end
      end
      if (sv && ready) begin
         noteY[sl][noteCnt[sl]] = 0;
         noteCnt[sl]++;
      end
      prevRow = row;
      prevKey = k;
      @(posedge clk);
      #1;
      checkOutput("d_out", {20'd0, d_out}, {20'd0, expPix});
      checkOutput("hit_pulse", {28'd0, hit_pulse}, {28'd0, expHit});
      checkOutput("miss_pulse", {28'd0, miss_pulse}, {28'd0, expMiss});
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      rdn = 1'b0;
      row_addr = 9'd5;
      col_addr = 10'd200;
      key = 4'b1111;
      spawn_valid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_d_out", {20'd0, d_out}, 32'd0);
      checkOutput("rst_hit", {28'd0, hit_pulse}, 32'd0);
      checkOutput("rst_miss", {28'd0, miss_pulse}, 32'd0);
      clearModel();
   endtask

   task automatic frameTicks(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 479, 100, 4'b0000, 1'b0, 2'd0);
         applyStimulus(1'b0, 0, 100, 4'b0000, 1'b0, 2'd0);
      end
   endtask

   initial begin
      logic [3:0] keyState;
      clearModel();
      doReset();

      $display("[TB] blanking and spawn into a full lane");
      applyStimulus(1'b1, 400, 257, 4'b1111, 1'b0, 2'd0);
      checkOutput("blank_pix", {20'd0, d_out}, 32'd0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 10, 100, 4'b0000, 1'b1, 2'd0);
      @(negedge clk);
      spawn_valid = 1'b0;
      spawn_lane = 2'd0;
      #1;
      checkOutput("full_lane_ready", {31'd0, spawn_ready}, 32'd0);
      checkOutput("full_lane_model", noteCnt[0], 32'd4);

      $display("[TB] scroll a lane-1 note to the hit line");
      doReset();
      applyStimulus(1'b1, 10, 100, 4'b0000, 1'b1, 2'd1);
      frameTicks(200);
      applyStimulus(1'b0, 400, 257, 4'b0000, 1'b0, 2'd0);
      checkOutput("note_at_400", {20'd0, d_out}, 32'h0f0);

      $display("[TB] hit inside and outside the window");
      doReset();
      applyStimulus(1'b0, 10, 100, 4'b0000, 1'b1, 2'd2);
      frameTicks(194);
      applyStimulus(1'b0, 10, 100, 4'b0100, 1'b0, 2'd0);
      checkOutput("hit_l2", {28'd0, hit_pulse}, 32'b0100);
      applyStimulus(1'b0, 10, 100, 4'b0100, 1'b0, 2'd0);
      checkOutput("hit_once", {28'd0, hit_pulse}, 32'd0);
      applyStimulus(1'b0, 390, 330, 4'b0000, 1'b1, 2'd2);
      checkOutput("hit_cleared", {20'd0, d_out}, 32'd0);
      frameTicks(150);
      applyStimulus(1'b0, 10, 100, 4'b0100, 1'b0, 2'd0);
      checkOutput("no_hit_300", {28'd0, hit_pulse}, 32'd0);

      $display("[TB] miss at the bottom edge");
      doReset();
      applyStimulus(1'b0, 10, 100, 4'b0000, 1'b1, 2'd3);
      frameTicks(239);
      applyStimulus(1'b0, 478, 400, 4'b0000, 1'b0, 2'd0);
      checkOutput("note_at_478", {20'd0, d_out}, 32'hff0);
      applyStimulus(1'b0, 0, 100, 4'b0000, 1'b0, 2'd0);
      checkOutput("miss_l3", {28'd0, miss_pulse}, 32'b1000);
      applyStimulus(1'b0, 478, 400, 4'b0000, 1'b0, 2'd0);
      checkOutput("miss_once", {28'd0, miss_pulse}, 32'd0);
      checkOutput("miss_cleared", {20'd0, d_out}, 32'd0);

      $display("[TB] spawn together with a frame tick");
      applyStimulus(1'b0, 10, 100, 4'b0000, 1'b1, 2'd0);
      frameTicks(10);
      applyStimulus(1'b0, 479, 100, 4'b0000, 1'b0, 2'd0);
      applyStimulus(1'b0, 0, 100, 4'b0000, 1'b1, 2'd0);
      applyStimulus(1'b0, 22, 200, 4'b0000, 1'b0, 2'd0);
      checkOutput("old_note_22", {20'd0, d_out}, 32'hf00);
      applyStimulus(1'b0, 0, 200, 4'b0000, 1'b0, 2'd0);
      checkOutput("new_note_0", {20'd0, d_out}, 32'hf00);
      applyStimulus(1'b0, 20, 200, 4'b0000, 1'b0, 2'd0);
      checkOutput("gap_row_20", {20'd0, d_out}, 32'd0);

      $display("[TB] reset mid-frame");
      doReset();
      applyStimulus(1'b0, 22, 200, 4'b0000, 1'b0, 2'd0);
      checkOutput("rst_no_note", {20'd0, d_out}, 32'd0);
      applyStimulus(1'b0, 0, 200, 4'b0000, 1'b0, 2'd0);
      applyStimulus(1'b0, 0, 200, 4'b0000, 1'b0, 2'd0);

      $display("[TB] randomized traffic");
      keyState = 4'b0000;
      for (int c = 0; c < 5000; c++) begin
         int row;
         logic r;
         r = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 7))
            0: row = 0;
            1: row = HROW;
            default: row = $urandom_range(1, 479);
         endcase
         if ($urandom_range(0, 5) == 0) keyState[$urandom_range(0, 3)] ^= 1'b1;
         applyStimulus(r, row, $urandom_range(150, 470), keyState,
                       ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
